dms_lpf_ctrl: RTL and testbench



---
 rtl/dms_ctrl_pkg.sv | 25 ++
 rtl/dms_lpf_tmr.sv | 19 +
 rtl/dms_lpf_ctrl.sv | 128 ++++++++++++
 tb/tb_dms_lpf_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/dms_ctrl_pkg.sv
// dms_ctrl_pkg: shared state encoding, default timing and resistor codes for the DMS loop-filter sequencer
package dms_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRECHARGE = 3'd1,
    FAST      = 3'd2,
    TRACK     = 3'd3,
    RETRY     = 3'd4,
    FAULT     = 3'd5
  } dms_lpf_state_t;
  localparam int PCHG_CYC_DEF   = 64;
  localparam int FAST_CYC_DEF   = 1024;
  localparam int LOCK_CNT_DEF   = 16;
  localparam int RAIL_CYC_DEF   = 32;
  localparam int MAX_RETRY_DEF  = 3;
  localparam int RSEL_W_DEF     = 3;
  localparam int RSEL_FAST_DEF  = 1;
  localparam int RSEL_TRACK_DEF = 5;
  // Timer width covering the longer of the two loaded intervals, never below 1 bit.
  function automatic int tmr_width(int a, int b);
    int m;
    m = a > b ? a : b;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/dms_lpf_tmr.sv
// dms_lpf_tmr: loadable down-counter with zero flag, shared by the precharge and fast-lock phases
//   clk, rst : clock, synchronous active-high reset
//   load_i   : load val_i this cycle (otherwise count down, holding at zero)
//   val_i    : load value
//   zero_o   : counter currently at zero
module dms_lpf_tmr #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] val_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load_i ? val_i : (cnt_q == '0 ? cnt_q : cnt_q - W'(1));
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/dms_lpf_ctrl.sv
// dms_lpf_ctrl: precharge / fast-lock / track sequencer for the DMS loop filter with bounded relock retries
//   clk, rst            : clock, synchronous active-high reset
//   start, stop         : begin acquisition (IDLE/FAULT only), abort to IDLE (highest priority)
//   lock_det            : CDR phase-lock indication
//   vctrl_hi, vctrl_lo  : control-voltage rail comparators
//   pchg_en, fast_en    : precharge switch, fast-lock bandwidth
//   res_sel             : series-resistor select code
//   locked, fault       : TRACK indicator, retries exhausted
//   retry_cnt, state_o  : relock attempts used, current state encoding
module dms_lpf_ctrl
  import dms_ctrl_pkg::*;
#(
  parameter int PCHG_CYC   = PCHG_CYC_DEF,
  parameter int FAST_CYC   = FAST_CYC_DEF,
  parameter int LOCK_CNT   = LOCK_CNT_DEF,
  parameter int RAIL_CYC   = RAIL_CYC_DEF,
  parameter int MAX_RETRY  = MAX_RETRY_DEF,
  parameter int RSEL_W     = RSEL_W_DEF,
  parameter int RSEL_FAST  = RSEL_FAST_DEF,
  parameter int RSEL_TRACK = RSEL_TRACK_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              lock_det,
  input  logic              vctrl_hi,
  input  logic              vctrl_lo,
  output logic              pchg_en,
  output logic              fast_en,
  output logic [RSEL_W-1:0] res_sel,
  output logic              locked,
  output logic              fault,
  output logic [1:0]        retry_cnt,
  output logic [2:0]        state_o
);
  localparam int TW = tmr_width(PCHG_CYC, FAST_CYC);
  localparam int LW = $clog2(LOCK_CNT + 1);
  localparam int RW = $clog2(RAIL_CYC + 1);
  localparam logic [RSEL_W-1:0] RS_FAST  = RSEL_W'(RSEL_FAST);
  localparam logic [RSEL_W-1:0] RS_TRACK = RSEL_W'(RSEL_TRACK);
  dms_lpf_state_t state_q, state_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [RW-1:0] rail_q, rail_d;
  logic [1:0]    retry_q, retry_d;
  logic [TW-1:0] tmr_val;
  logic          tmr_ld, tmr_zero, oow, lock_hit, rail_hit, retry_max;
  dms_lpf_tmr #(.W(TW)) u_tmr (
    .clk    (clk),
    .rst    (rst),
    .load_i (tmr_ld),
    .val_i  (tmr_val),
    .zero_o (tmr_zero)
  );
  assign oow       = vctrl_hi | vctrl_lo;
  // "Reaching" the threshold is judged on this cycle's input so the count completes on the edge it hits.
  assign lock_hit  = lock_det && lock_q >= LW'(LOCK_CNT - 1);
  assign rail_hit  = oow && rail_q >= RW'(RAIL_CYC - 1);
  // The 2-bit counter also stops at 3 so it cannot wrap for larger retry limits.
  assign retry_max = int'(retry_q) >= MAX_RETRY || retry_q == 2'd3;
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    rail_d  = rail_q;
    retry_d = retry_q;
    tmr_ld  = 1'b0;
    tmr_val = TW'(PCHG_CYC - 1);
    case (state_q)
      IDLE, FAULT: if (start) begin
        state_d = PRECHARGE;
        tmr_ld  = 1'b1;
        retry_d = '0;
      end
      PRECHARGE: if (tmr_zero) begin
        state_d = FAST;
        tmr_ld  = 1'b1;
        tmr_val = TW'(FAST_CYC - 1);
        lock_d  = '0;
      end
      FAST: begin
        lock_d = !lock_det ? '0 : lock_hit ? LW'(LOCK_CNT) : lock_q + LW'(1);
        if (lock_hit) begin
          state_d = TRACK;
          rail_d  = '0;
        end else if (tmr_zero) state_d = RETRY;
      end
      TRACK: begin
        rail_d = !oow ? '0 : rail_hit ? RW'(RAIL_CYC) : rail_q + RW'(1);
        if (rail_hit) state_d = RETRY;
      end
      RETRY: if (retry_max) state_d = FAULT;
      else begin
        state_d = PRECHARGE;
        tmr_ld  = 1'b1;
        retry_d = retry_q + 2'd1;
      end
      default: state_d = IDLE;
    endcase
    if (stop) begin
      state_d = IDLE;
      lock_d  = '0;
      rail_d  = '0;
      retry_d = '0;
      tmr_ld  = 1'b1;
      tmr_val = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      lock_q  <= '0;
      rail_q  <= '0;
      retry_q <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      rail_q  <= rail_d;
      retry_q <= retry_d;
    end
  end
  assign pchg_en   = state_q == PRECHARGE;
  assign fast_en   = state_q == FAST;
  assign res_sel   = (pchg_en || fast_en) ? RS_FAST : RS_TRACK;
  assign locked    = state_q == TRACK;
  assign fault     = state_q == FAULT;
  assign retry_cnt = retry_q;
  assign state_o   = state_q;
endmodule

// File: tb/tb_dms_lpf_ctrl.sv
// tb_dms_lpf_ctrl: scoreboard bench; expected output snapshots with their change cycle are queued, a monitor pops on every output change
module tb_dms_lpf_ctrl;
  localparam logic [2:0] S_IDLE = 3'd0, S_PCH = 3'd1, S_FAST = 3'd2, S_TRACK = 3'd3, S_RETRY = 3'd4, S_FAULT = 3'd5;
  typedef struct {
    string       nm;
    int          cyc;
    logic [11:0] v;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, lock_det = 1'b0, vctrl_hi = 1'b0, vctrl_lo = 1'b0;
  logic t_start = 1'b0, t_lock = 1'b0;
  logic pchg_en, fast_en, locked, fault, t_pchg_en, t_fast_en, t_locked, t_fault;
  logic [2:0] res_sel, state_o, t_res_sel, t_state_o;
  logic [1:0] retry_cnt, t_retry_cnt;
  logic [11:0] cur0, cur1, prev0 = 'x, prev1 = 'x;
  exp_t q0[$], q1[$];
  int cyc = 0, n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dms_lpf_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .lock_det(lock_det),
    .vctrl_hi(vctrl_hi), .vctrl_lo(vctrl_lo), .pchg_en(pchg_en), .fast_en(fast_en),
    .res_sel(res_sel), .locked(locked), .fault(fault), .retry_cnt(retry_cnt), .state_o(state_o)
  );
  dms_lpf_ctrl #(.FAST_CYC(16)) u_tie (
    .clk(clk), .rst(rst), .start(t_start), .stop(1'b0), .lock_det(t_lock),
    .vctrl_hi(1'b0), .vctrl_lo(1'b0), .pchg_en(t_pchg_en), .fast_en(t_fast_en),
    .res_sel(t_res_sel), .locked(t_locked), .fault(t_fault), .retry_cnt(t_retry_cnt), .state_o(t_state_o)
  );
  function automatic logic [11:0] snap(logic [2:0] st, logic [1:0] rc);
    logic [2:0] rs;
    rs = (st == S_PCH || st == S_FAST) ? 3'd1 : 3'd5;
    return {st, st == S_PCH, st == S_FAST, rs, st == S_TRACK, st == S_FAULT, rc};
  endfunction
  task automatic push(int which, string nm, int c, logic [2:0] st, logic [1:0] rc);
    exp_t e;
    e.nm  = nm;
    e.cyc = c;
    e.v   = snap(st, rc);
    if (which == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask
  task automatic check(exp_t e, logic [11:0] a);
    n_chk++;
    if (a === e.v && cyc == e.cyc) n_pass++;
    else $display("FAIL %s: outputs %h at cycle %0d, required %h at cycle %0d", e.nm, a, cyc, e.v, e.cyc);
  endtask
  task automatic at(int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask
  always @(negedge clk) begin
    cur0 = {state_o, pchg_en, fast_en, res_sel, locked, fault, retry_cnt};
    cur1 = {t_state_o, t_pchg_en, t_fast_en, t_res_sel, t_locked, t_fault, t_retry_cnt};
    if (cur0 !== prev0) begin
      if (q0.size() == 0) begin
        n_chk++;
        $display("FAIL main_unexpected: outputs %h at cycle %0d, required no change", cur0, cyc);
      end else check(q0.pop_front(), cur0);
      prev0 = cur0;
    end
    if (cur1 !== prev1) begin
      if (q1.size() == 0) begin
        n_chk++;
        $display("FAIL tie_unexpected: outputs %h at cycle %0d, required no change", cur1, cyc);
      end else check(q1.pop_front(), cur1);
      prev1 = cur1;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d, required finish", cyc);
    $fatal(1);
  end
  initial begin
    push(0, "reset", 1, S_IDLE, 2'd0);
    push(1, "tie_reset", 1, S_IDLE, 2'd0);
    at(3);
    rst = 1'b0;
    // Acquisition: 64-cycle precharge, 15-cycle lock burst then 16-cycle lock.
    at(5);
    start = 1'b1;
    push(0, "precharge", 6, S_PCH, 2'd0);
    push(0, "fast_after_64", 70, S_FAST, 2'd0);
    push(0, "track_on_16th", 102, S_TRACK, 2'd0);
    at(6);
    start = 1'b0;
    at(70);
    lock_det = 1'b1;
    at(85);
    lock_det = 1'b0;
    at(86);
    lock_det = 1'b1;
    at(102);
    lock_det = 1'b0;
    // Rail: 31 high cycles survive, then 16 both-high + 16 low-only trigger a relock.
    vctrl_hi = 1'b1;
    push(0, "rail_retry", 166, S_RETRY, 2'd0);
    push(0, "relock_pch", 167, S_PCH, 2'd1);
    push(0, "relock_fast", 231, S_FAST, 2'd1);
    at(133);
    vctrl_hi = 1'b0;
    at(134);
    vctrl_hi = 1'b1;
    vctrl_lo = 1'b1;
    at(150);
    vctrl_hi = 1'b0;
    at(166);
    vctrl_lo = 1'b0;
    // stop beats start; IDLE leaves only once stop drops.
    at(240);
    stop  = 1'b1;
    start = 1'b1;
    push(0, "stop_idle", 241, S_IDLE, 2'd0);
    push(0, "restart_pch", 243, S_PCH, 2'd0);
    push(0, "rst_idle", 254, S_IDLE, 2'd0);
    at(242);
    stop = 1'b0;
    at(243);
    start = 1'b0;
    at(253);
    rst = 1'b1;
    at(254);
    rst = 1'b0;
    // Short-timeout instance: lock completes on the same cycle the timer expires.
    at(260);
    t_start = 1'b1;
    t_lock  = 1'b1;
    push(1, "tie_pch", 261, S_PCH, 2'd0);
    push(1, "tie_fast", 325, S_FAST, 2'd0);
    push(1, "tie_track", 341, S_TRACK, 2'd0);
    at(261);
    t_start = 1'b0;
    // Four timeouts, then FAULT, then restart clears retry_cnt.
    at(300);
    start = 1'b1;
    for (int r = 0; r < 4; r++) begin
      push(0, $sformatf("pch%0d", r), 301 + r * 1089, S_PCH, 2'(r));
      push(0, $sformatf("fast%0d", r), 365 + r * 1089, S_FAST, 2'(r));
      push(0, $sformatf("timeout%0d", r), 1389 + r * 1089, S_RETRY, 2'(r));
    end
    push(0, "fault", 4657, S_FAULT, 2'd3);
    push(0, "fault_restart", 4671, S_PCH, 2'd0);
    push(0, "final_stop", 4681, S_IDLE, 2'd0);
    at(301);
    start = 1'b0;
    at(4670);
    start = 1'b1;
    at(4671);
    start = 1'b0;
    at(4680);
    stop = 1'b1;
    at(4682);
    stop = 1'b0;
    at(4690);
    n_chk++;
    if (q0.size() == 0) n_pass++;
    else $display("FAIL main_drain: %0d expected changes never seen, required 0", q0.size());
    n_chk++;
    if (q1.size() == 0) n_pass++;
    else $display("FAIL tie_drain: %0d expected changes never seen, required 0", q1.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
